interrupt_vector_mc: RTL

// - Multi-cycle Nios II custom-instruction interrupt vector unit; parametrised successor of the fixed 32-IRQ combinational vector.
// - Snapshots ipending at start and applies a programmable enable mask.
// - Scans the snapshot SCAN_WIDTH bits per cycle, lowest index = highest priority.
// - Returns {no_irq, offset}, where offset = winning_irq << VECTOR_STRIDE_LOG2.
// - Sits on the CPU custom-instruction port; ISR dispatch code adds offset to the vector table base.

---
 rtl/interrupt_vector_pkg.sv | 24 ++
 rtl/interrupt_vector_chunk_pri.sv | 22 ++
 rtl/interrupt_vector_mc.sv | 125 ++++++++++++
 3 files changed

// File: rtl/interrupt_vector_pkg.sv
// Shared types and constants for the multi-cycle interrupt vector custom instruction.
package interrupt_vector_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [1:0] OP_VEC         = 2'd0;
   localparam logic [1:0] OP_WRMASK      = 2'd1;
   localparam logic [1:0] OP_RDMASK      = 2'd2;
   localparam logic [1:0] OP_VEC_ONESHOT = 2'd3;

   localparam logic [31:0] NO_IRQ_RESULT = 32'h8000_0000;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/interrupt_vector_chunk_pri.sv
// Lowest-set-bit priority encoder over one scan chunk; bit 0 is the highest priority.
module interrupt_vector_chunk_pri
   import interrupt_vector_pkg::*;
#(
   parameter int SCAN_WIDTH = 8,
   parameter int IDX_W      = (clog2(SCAN_WIDTH) > 0) ? clog2(SCAN_WIDTH) : 1
) (
   input  logic [SCAN_WIDTH-1:0] chunk,
   output logic                  hit,
   output logic [IDX_W-1:0]      idx
);

   always_comb begin
      hit = |chunk;
      idx = '0;
      // Walk downward so the lowest set bit is the last one written.
      for (int i = SCAN_WIDTH - 1; i >= 0; i--) begin
         if (chunk[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/interrupt_vector_mc.sv
// Multi-cycle interrupt vector unit: snapshots masked pending IRQs and scans them a chunk per cycle.
module interrupt_vector_mc
   import interrupt_vector_pkg::*;
#(
   parameter int          NUM_IRQ            = 32,
   parameter int          SCAN_WIDTH         = 8,
   parameter int          VECTOR_STRIDE_LOG2 = 3,
   parameter logic [31:0] MASK_RESET         = {32{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_en,
   input  logic               start,
   input  logic [1:0]         n,
   input  logic [31:0]        dataa,
   input  logic               estatus,
   input  logic [NUM_IRQ-1:0] ipending,
   output logic [31:0]        result,
   output logic               done
);

   localparam int NUM_CHUNK = (NUM_IRQ + SCAN_WIDTH - 1) / SCAN_WIDTH;
   localparam int PAD_W     = NUM_CHUNK * SCAN_WIDTH;
   localparam int K_W       = (clog2(NUM_CHUNK) > 0) ? clog2(NUM_CHUNK) : 1;
   localparam int IDX_W     = (clog2(SCAN_WIDTH) > 0) ? clog2(SCAN_WIDTH) : 1;
   localparam logic [K_W-1:0] LAST_K = K_W'(NUM_CHUNK - 1);

   state_t               state;
   logic [K_W-1:0]       k;
   logic [NUM_IRQ-1:0]   mask;
   logic [PAD_W-1:0]     snap;
   logic [NUM_IRQ-1:0]   sel_mask;
   logic                 vec_issue;
   logic [SCAN_WIDTH-1:0] chunk;
   logic                 hit;
   logic [IDX_W-1:0]     idx;
   logic [30:0]          win_irq;
   logic [30:0]          win_off;

   assign vec_issue = clk_en && (state == IDLE) && start &&
                      ((n == OP_VEC) || (n == OP_VEC_ONESHOT));
   assign sel_mask  = (n == OP_VEC_ONESHOT) ? dataa[NUM_IRQ-1:0] : mask;

   // Snapshot is pure data; the last chunk's padding bits stay zero.
   always_ff @(posedge clk) begin
      if (vec_issue) snap <= PAD_W'(ipending & sel_mask);
   end

   assign chunk = snap[int'(k) * SCAN_WIDTH +: SCAN_WIDTH];

   interrupt_vector_chunk_pri #(
      .SCAN_WIDTH (SCAN_WIDTH),
      .IDX_W      (IDX_W)
   ) u_chunk_pri (
      .chunk (chunk),
      .hit   (hit),
      .idx   (idx)
   );

   assign win_irq = 31'(k) * 31'(SCAN_WIDTH) + 31'(idx);
   assign win_off = win_irq << VECTOR_STRIDE_LOG2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         result <= '0;
         mask   <= MASK_RESET[NUM_IRQ-1:0];
         k      <= '0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  k <= '0;
                  case (n)
                     OP_WRMASK: begin
                        result <= 32'(mask);
                        mask   <= dataa[NUM_IRQ-1:0];
                        state  <= FIN;
                        done   <= 1'b1;
                     end
                     OP_RDMASK: begin
                        result <= 32'(mask);
                        state  <= FIN;
                        done   <= 1'b1;
                     end
                     default: begin
                        // Interrupts globally disabled: answer immediately without scanning.
                        if (!estatus) begin
                           result <= NO_IRQ_RESULT;
                           state  <= FIN;
                           done   <= 1'b1;
                        end else begin
                           state <= SCAN;
                        end
                     end
                  endcase
               end
            end
            SCAN: begin
               if (hit) begin
                  result <= {1'b0, win_off};
                  state  <= FIN;
                  done   <= 1'b1;
               end else if (k == LAST_K) begin
                  result <= NO_IRQ_RESULT;
                  state  <= FIN;
                  done   <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
